mips_mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS core: a Moore state machine that sequences a shared-memory, multicycle datapath over 3–5 clocks per instruction. It replaces the single-cycle `ctrl` decoder when the core is built with one unified instruction/data memory. It decodes `op` and `funct` from the instruction register. It drives every datapath enable and mux select, and reports unsupported opcodes.

---
 rtl/mips_mc_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM (Moore) for a shared
// instruction/data memory datapath. It sequences FETCH, DECODE and the
// per-class execute/writeback states, and drives every datapath enable
// and mux select.
// Optional feature macro: MIPS_MC_MEMRDY_EN adds a memrdy input. FETCH,
// MEMRD and MEMWR then stall until memory reports ready.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MIPS_MC_MEMRDY_EN
  input  logic       memrdy,
`endif
  output logic       pcen,
  output logic       iord,
  output logic       memwrt,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrt,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluctrl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // One control word per state; pcwrite/branch are internal and feed pcen.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrt;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrt;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluctrl;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct decode; unknown functs fall back to add without a trap.
  function automatic logic [2:0] alu_dec(input logic [5:0] f);
    logic [2:0] a;
    case (f)
      6'b100000: a = ALU_ADD;
      6'b100010: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      default:   a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Control word for a state; everything not named is 0, ALU defaults to add.
  function automatic ctl_t ctl_of(input state_t s, input logic [5:0] f);
    ctl_t c;
    c         = '0;
    c.aluctrl = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
      end
      S_DECODE: c.alusrcb = 2'b11;   // branch target into ALUOut
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrt   = 1'b1;
      end
      S_MEMWR: begin
        c.iord   = 1'b1;
        c.memwrt = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluctrl = alu_dec(f);
      end
      S_ALUWB: begin
        c.regdst = 1'b1;
        c.regwrt = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluctrl = ALU_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB: c.regwrt = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = c;
    endcase
    return c;
  endfunction

  localparam ctl_t CTL_FETCH = ctl_of(S_FETCH, 6'b000000);

  state_t state, nxt;
  ctl_t   ctl, gctl;
  logic   rdy, op_ok, fetch_wait;

`ifdef MIPS_MC_MEMRDY_EN
  assign rdy = memrdy;
`else
  assign rdy = 1'b1;
`endif

  // Supported-opcode check, used for the DECODE illegal pulse.
  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_ok = 1'b1;
      default:                                       op_ok = 1'b0;
    endcase
  end

  // Next-state logic; memory states hold until ready.
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // State and registered control word. Loading the word from the next state
  // keeps the outputs glitch-free and aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ctl   <= CTL_FETCH;
    end else begin
      state <= nxt;
      ctl   <= ctl_of(nxt, funct);
    end
  end

  // Reset gates every output immediately, so no IR, PC, register file or
  // memory update can slip through while the FSM is being forced to FETCH.
  assign gctl       = rst ? '0 : ctl;
  assign fetch_wait = (state == S_FETCH) && !rdy;

  assign iord     = gctl.iord;
  assign memwrt   = gctl.memwrt;
  assign irwrite  = gctl.irwrite & ~fetch_wait;
  assign regdst   = gctl.regdst;
  assign memtoreg = gctl.memtoreg;
  assign regwrt   = gctl.regwrt;
  assign alusrca  = gctl.alusrca;
  assign alusrcb  = gctl.alusrcb;
  assign pcsrc    = gctl.pcsrc;
  assign aluctrl  = gctl.aluctrl;
  assign pcen     = (gctl.pcwrite & ~fetch_wait) | (gctl.branch & zero);
  assign illegal  = ~rst & (state == S_DECODE) & ~op_ok;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl. Outputs are packed into one word and
// compared cycle by cycle against hand-written per-state constants.
module tb_mips_mc_ctrl;
  logic       clk, rst, zero;
  logic [5:0] op, funct;
`ifdef MIPS_MC_MEMRDY_EN
  logic       memrdy;
`endif
  logic       pcen, iord, memwrt, irwrite, regdst, memtoreg, regwrt, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctrl;
  logic [15:0] obs;
  int nvec = 0;
  int nmis = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
`ifdef MIPS_MC_MEMRDY_EN
    .memrdy(memrdy),
`endif
    .pcen(pcen), .iord(iord), .memwrt(memwrt), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrt(regwrt), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluctrl(aluctrl), .illegal(illegal)
  );

  // {pcen iord memwrt irwrite regdst memtoreg regwrt alusrca, alusrcb, pcsrc, aluctrl, illegal}
  assign obs = {pcen, iord, memwrt, irwrite, regdst, memtoreg, regwrt, alusrca,
                alusrcb, pcsrc, aluctrl, illegal};

  localparam logic [15:0] W_F   = 16'b10010000_01_00_010_0;
  localparam logic [15:0] W_D   = 16'b00000000_11_00_010_0;
  localparam logic [15:0] W_DI  = 16'b00000000_11_00_010_1;
  localparam logic [15:0] W_MA  = 16'b00000001_10_00_010_0;
  localparam logic [15:0] W_MR  = 16'b01000000_00_00_010_0;
  localparam logic [15:0] W_MW  = 16'b00000110_00_00_010_0;
  localparam logic [15:0] W_WR  = 16'b01100000_00_00_010_0;
  localparam logic [15:0] W_AW  = 16'b00001010_00_00_010_0;
  localparam logic [15:0] W_B1  = 16'b10000001_00_01_110_0;
  localparam logic [15:0] W_B0  = 16'b00000001_00_01_110_0;
  localparam logic [15:0] W_IW  = 16'b00000010_00_00_010_0;
  localparam logic [15:0] W_J   = 16'b10000000_00_10_010_0;
  localparam logic [15:0] W_FW  = 16'b00000000_01_00_010_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b1;
`ifdef MIPS_MC_MEMRDY_EN
    memrdy = 1'b1;
`endif
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (obs !== 16'h0) begin
        nmis++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs, 16'h0);
      end
      tick();
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_lw;
    logic [15:0] e [0:5];
    e = '{W_F, W_D, W_MA, W_MR, W_MW, W_F};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL lw cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_rtype;
    logic [5:0]  f [0:5];
    logic [2:0]  a [0:5];
    logic [15:0] e [0:4];
    f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    a = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = f[k];
      e = '{W_F, W_D, {8'b00000001, 2'b00, 2'b00, a[k], 1'b0}, W_AW, W_F};
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (obs !== e[i]) begin
          nmis++;
          $display("FAIL rtype funct=%b cyc%0d: got %b want %b", f[k], i + 1, obs, e[i]);
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_beq;
    logic [15:0] e [0:3];
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      e = '{W_F, W_D, (z == 1) ? W_B1 : W_B0, W_F};
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (obs !== e[i]) begin
          nmis++;
          $display("FAIL beq zero=%0d cyc%0d: got %b want %b", z, i + 1, obs, e[i]);
        end
        if (i < 3) tick();
      end
    end
    zero = 1'b1;
  endtask

  task automatic test_sw_addi;
    logic [15:0] e [0:4];
    op = 6'b101011;
    e = '{W_F, W_D, W_MA, W_WR, W_F};
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL sw cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 4) tick();
    end
    op = 6'b001000;
    e = '{W_F, W_D, W_MA, W_IW, W_F};
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL addi cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_jump;
    logic [15:0] e [0:3];
    e = '{W_F, W_D, W_J, W_F};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL j cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal;
    logic [5:0]  ops [0:1];
    logic [15:0] e [0:2];
    ops = '{6'b111111, 6'b000011};
    e = '{W_F, W_DI, W_F};
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs !== e[i]) begin
          nmis++;
          $display("FAIL illegal op=%b cyc%0d: got %b want %b", ops[k], i + 1, obs, e[i]);
        end
        if (i < 2) tick();
      end
    end
  endtask

  task automatic test_reset_memwr;
    logic [15:0] e [0:4];
    op = 6'b101011;
    tick(); tick(); tick();
    nvec++;
    if (obs !== W_WR) begin
      nmis++;
      $display("FAIL rst_memwr pre: got %b want %b", obs, W_WR);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (memwrt !== 1'b0 || obs !== 16'h0) begin
      nmis++;
      $display("FAIL rst_memwr async: got memwrt=%b obs=%b want 0", memwrt, obs);
    end
    tick();
    rst = 1'b0;
    #1;
    e = '{W_F, W_D, W_MA, W_WR, W_F};
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL rst_memwr resume cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 4) tick();
    end
  endtask

`ifdef MIPS_MC_MEMRDY_EN
  task automatic test_memrdy;
    logic [15:0] e [0:5];
    op = 6'b100011;
    memrdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (obs !== W_FW) begin
        nmis++;
        $display("FAIL memrdy wait%0d: got %b want %b", i, obs, W_FW);
      end
      tick();
    end
    memrdy = 1'b1;
    #1;
    e = '{W_F, W_D, W_MA, W_MR, W_MW, W_F};
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (obs !== e[i]) begin
        nmis++;
        $display("FAIL memrdy lw cyc%0d: got %b want %b", i + 1, obs, e[i]);
      end
      if (i < 5) tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_addi();
    test_jump();
    test_illegal();
    test_reset_memwr();
`ifdef MIPS_MC_MEMRDY_EN
    test_memrdy();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
